// File: rtl/pkg_bool.sv
// Shared boolean constants for control logic.
package pkg_bool;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
endpackage

// File: rtl/pkg_seq.sv
// Types shared by the loop sequencer and its bench.
package pkg_seq;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/loop_level.sv
// One level of the loop nest: bounded index that wraps to 0 and reports its carry.
module loop_level #(
    parameter int DWidth = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [DWidth-1:0] bound_i,
    output logic [DWidth-1:0] idx_o,
    output logic              last_o,
    output logic              wrap_o
);
    logic [DWidth-1:0] idx_q, idx_d;

    // bound_i is nonzero whenever the level is incremented, so bound-1 never underflows in use
    assign last_o = (idx_q == (bound_i - DWidth'(1)));
    assign wrap_o = inc_i && last_o;
    assign idx_o  = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr_i || wrap_o) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = idx_q + DWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/loop_sequencer.sv
// Three-deep loop nest generator (row, col, dep) with valid/ready tuple handshake.
//   state | meaning
//   IDLE  | waiting for start_i, bounds latched on start
//   RUN   | presenting tuples, advancing on handshake
//   DONE  | one-cycle completion pulse on done_o
module loop_sequencer
    import pkg_seq::*;
    import pkg_bool::*;
#(
    parameter int DWidth = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DWidth-1:0] m_i,
    input  logic [DWidth-1:0] n_i,
    input  logic [DWidth-1:0] k_i,
    output logic              idx_valid_o,
    input  logic              idx_ready_i,
    output logic [DWidth-1:0] row_o,
    output logic [DWidth-1:0] col_o,
    output logic [DWidth-1:0] dep_o,
    output logic              first_k_o,
    output logic              last_k_o,
    output logic              busy_o,
    output logic              done_o
);
    state_e            state_q, state_d;
    logic [DWidth-1:0] m_q, n_q, k_q, m_d, n_d, k_d;
    logic              hs, final_hs, lvl_clr;
    logic              dep_last, col_last, row_last;
    logic              dep_wrap, col_wrap, row_wrap;

    assign hs       = idx_valid_o && idx_ready_i;
    assign final_hs = hs && dep_last && col_last && row_last;
    // abort wins over a same-cycle handshake because clear overrides increment in each level
    assign lvl_clr  = abort_i || (state_q != RUN) || row_wrap;

    loop_level #(.DWidth(DWidth)) u_dep (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(lvl_clr), .inc_i(hs),
        .bound_i(k_q), .idx_o(dep_o), .last_o(dep_last), .wrap_o(dep_wrap)
    );
    loop_level #(.DWidth(DWidth)) u_col (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(lvl_clr), .inc_i(dep_wrap),
        .bound_i(n_q), .idx_o(col_o), .last_o(col_last), .wrap_o(col_wrap)
    );
    loop_level #(.DWidth(DWidth)) u_row (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(lvl_clr), .inc_i(col_wrap),
        .bound_i(m_q), .idx_o(row_o), .last_o(row_last), .wrap_o(row_wrap)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    m_d = m_i;
                    n_d = n_i;
                    k_d = k_i;
                    if ((m_i == '0) || (n_i == '0) || (k_i == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (final_hs) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            m_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            k_q     <= k_d;
        end
    end

    assign idx_valid_o = (state_q == RUN);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE) ? !abort_i : FALSE;
    assign first_k_o   = idx_valid_o && (dep_o == '0);
    assign last_k_o    = idx_valid_o && dep_last;
endmodule

// File: tb/tb_loop_sequencer.sv
// Scoreboard bench for loop_sequencer (8-bit and 4-bit instances).
module tb_loop_sequencer;
    typedef struct {
        logic [7:0] r;
        logic [7:0] c;
        logic [7:0] d;
        logic       f;
        logic       l;
    } tup_t;

    tup_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ready = 1'b0;
    logic       abort8 = 1'b0, abort4 = 1'b0;
    logic       start8 = 1'b0, start4 = 1'b0;
    logic [7:0] m8 = '0, n8 = '0, k8 = '0;
    logic [3:0] m4 = '0, n4 = '0, k4 = '0;
    logic       valid8, first8, last8, busy8, done8;
    logic [7:0] row8, col8, dep8;
    logic       valid4, first4, last4, busy4, done4;
    logic [3:0] row4, col4, dep4;

    always #5 clk = ~clk;

    loop_sequencer #(.DWidth(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .abort_i(abort8),
        .m_i(m8), .n_i(n8), .k_i(k8), .idx_valid_o(valid8), .idx_ready_i(ready),
        .row_o(row8), .col_o(col8), .dep_o(dep8), .first_k_o(first8), .last_k_o(last8),
        .busy_o(busy8), .done_o(done8)
    );

    loop_sequencer #(.DWidth(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .abort_i(abort4),
        .m_i(m4), .n_i(n4), .k_i(k4), .idx_valid_o(valid4), .idx_ready_i(ready),
        .row_o(row4), .col_o(col4), .dep_o(dep4), .first_k_o(first4), .last_k_o(last4),
        .busy_o(busy4), .done_o(done4)
    );

    task automatic push_nest(input int m, input int n, input int k);
        tup_t t;
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
                for (int l = 0; l < k; l++) begin
                    t.r = 8'(i); t.c = 8'(j); t.d = 8'(l);
                    t.f = (l == 0); t.l = (l == k - 1);
                    sb.push_back(t);
                end
    endtask

    // Called on a negedge; returns on the negedge after the start edge.
    task automatic start_nest(input bit use4, input int m, input int n, input int k);
        if (use4) begin
            m4 = 4'(m); n4 = 4'(n); k4 = 4'(k); start4 = 1'b1;
        end else begin
            m8 = 8'(m); n8 = 8'(n); k8 = 8'(k); start8 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    // Scoreboard consumer: compares every presented tuple against the queue head, pops on handshake.
    task automatic sb_drain(input bit use4, input bit rnd, input int budget, input int start_at,
                            output int hs, output int ndone, output int last_hs, output int done_at);
        logic       v, f, l, d, rdy;
        logic [7:0] r, c, dp;
        tup_t       e;
        bit         finished;
        hs = 0; ndone = 0; last_hs = -1; done_at = -1; finished = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            v  = use4 ? valid4 : valid8;
            r  = use4 ? {4'b0, row4} : row8;
            c  = use4 ? {4'b0, col4} : col8;
            dp = use4 ? {4'b0, dep4} : dep8;
            f  = use4 ? first4 : first8;
            l  = use4 ? last4 : last8;
            d  = use4 ? done4 : done8;
            if (use4) start4 = (cyc == start_at); else start8 = (cyc == start_at);
            rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ready = rdy;
            if (d) begin
                ndone++;
                done_at = cyc;
            end
            if (v) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL extra_tuple cyc=%0d got=(%0d,%0d,%0d) expected no tuple", cyc, r, c, dp);
                end else begin
                    e = sb[0];
                    if ({r, c, dp, f, l} !== {e.r, e.c, e.d, e.f, e.l}) begin
                        failures++;
                        $display("FAIL tuple cyc=%0d got=(%0d,%0d,%0d,f%0b,l%0b) expected=(%0d,%0d,%0d,f%0b,l%0b)",
                                 cyc, r, c, dp, f, l, e.r, e.c, e.d, e.f, e.l);
                    end
                    if (rdy) begin
                        void'(sb.pop_front());
                        hs++;
                        last_hs = cyc;
                    end
                end
            end
            if (sb.size() == 0 && ndone > 0) begin
                finished = 1;
                break;
            end
            @(negedge clk);
        end
        start4 = 1'b0;
        start8 = 1'b0;
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL drain_timeout remaining=%0d dones=%0d expected remaining=0 dones>=1", sb.size(), ndone);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({valid8, busy8, done8, first8, last8, row8, col8, dep8} !== '0) begin
            failures++;
            $display("FAIL reset8 got v%0b b%0b d%0b f%0b l%0b (%0d,%0d,%0d) expected all 0",
                     valid8, busy8, done8, first8, last8, row8, col8, dep8);
        end
        checks++;
        if ({valid4, busy4, done4, first4, last4, row4, col4, dep4} !== '0) begin
            failures++;
            $display("FAIL reset4 got v%0b b%0b d%0b (%0d,%0d,%0d) expected all 0",
                     valid4, busy4, done4, row4, col4, dep4);
        end
    endtask

    task automatic test_full_run();
        int hs, nd, lh, dc;
        push_nest(2, 3, 4);
        start_nest(0, 2, 3, 4);
        sb_drain(0, 0, 100, -1, hs, nd, lh, dc);
        checks++;
        if (hs !== 24) begin failures++; $display("FAIL full_hs got=%0d expected=24", hs); end
        checks++;
        if (nd !== 1) begin failures++; $display("FAIL full_done_count got=%0d expected=1", nd); end
        checks++;
        if (dc !== lh + 1) begin failures++; $display("FAIL full_done_timing got=%0d expected=%0d", dc, lh + 1); end
        @(negedge clk);
        checks++;
        if ({busy8, valid8, done8} !== 3'b000) begin
            failures++;
            $display("FAIL full_idle got=%b expected=000", {busy8, valid8, done8});
        end
    endtask

    task automatic test_stall();
        int hs, nd, lh, dc;
        push_nest(2, 2, 2);
        start_nest(0, 2, 2, 2);
        sb_drain(0, 1, 400, -1, hs, nd, lh, dc);
        checks++;
        if (hs !== 8) begin failures++; $display("FAIL stall_hs got=%0d expected=8", hs); end
        checks++;
        if (nd !== 1 || dc !== lh + 1) begin
            failures++;
            $display("FAIL stall_done got count=%0d at=%0d expected count=1 at=%0d", nd, dc, lh + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_bound();
        start_nest(0, 1, 1, 0);
        checks++;
        if ({busy8, done8, valid8} !== 3'b110) begin
            failures++;
            $display("FAIL zero_done got=%b expected=110", {busy8, done8, valid8});
        end
        @(negedge clk);
        checks++;
        if ({busy8, done8, valid8} !== 3'b000) begin
            failures++;
            $display("FAIL zero_idle got=%b expected=000", {busy8, done8, valid8});
        end
    endtask

    task automatic test_abort();
        tup_t e;
        int   hs, nd, lh, dc;
        push_nest(3, 3, 3);
        ready = 1'b1;
        start_nest(0, 3, 3, 3);
        for (int i = 0; i < 5; i++) begin
            e = sb.pop_front();
            checks++;
            if ({valid8, row8, col8, dep8} !== {1'b1, e.r, e.c, e.d}) begin
                failures++;
                $display("FAIL abort_pre_tuple i=%0d got=v%0b(%0d,%0d,%0d) expected=v1(%0d,%0d,%0d)",
                         i, valid8, row8, col8, dep8, e.r, e.c, e.d);
            end
            if (i == 4) abort8 = 1'b1;
            @(negedge clk);
        end
        abort8 = 1'b0;
        checks++;
        if ({busy8, valid8, done8, row8, col8, dep8} !== '0) begin
            failures++;
            $display("FAIL abort_idle got b%0b v%0b d%0b (%0d,%0d,%0d) expected all 0",
                     busy8, valid8, done8, row8, col8, dep8);
        end
        @(negedge clk);
        checks++;
        if ({busy8, done8} !== 2'b00) begin
            failures++;
            $display("FAIL abort_no_done got=%b expected=00", {busy8, done8});
        end
        sb.delete();
        push_nest(1, 1, 1);
        start_nest(0, 1, 1, 1);
        sb_drain(0, 0, 20, -1, hs, nd, lh, dc);
        checks++;
        if (hs !== 1 || nd !== 1) begin
            failures++;
            $display("FAIL abort_restart got hs=%0d done=%0d expected hs=1 done=1", hs, nd);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int bad;
        ready = 1'b1;
        start_nest(0, 2, 3, 4);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({valid8, busy8, done8, first8, last8, row8, col8, dep8} !== '0) begin
            failures++;
            $display("FAIL async_reset got v%0b b%0b d%0b (%0d,%0d,%0d) expected all 0",
                     valid8, busy8, done8, row8, col8, dep8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done8 || busy8) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL post_reset_activity got=%0d expected=0", bad); end
    endtask

    task automatic test_dwidth4();
        int hs, nd, lh, dc, bad;
        push_nest(1, 1, 15);
        start_nest(1, 1, 1, 15);
        sb_drain(1, 0, 60, 5, hs, nd, lh, dc);
        checks++;
        if (hs !== 15) begin failures++; $display("FAIL w4_hs got=%0d expected=15", hs); end
        checks++;
        if (nd !== 1 || dc !== lh + 1) begin
            failures++;
            $display("FAIL w4_done got count=%0d at=%0d expected count=1 at=%0d", nd, dc, lh + 1);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy4 || valid4) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL w4_start_queued got=%0d expected=0", bad); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_full_run();
        test_stall();
        test_zero_bound();
        test_abort();
        test_reset_mid_run();
        test_dwidth4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
